// File: rtl/multicycle_adder.sv
// multicycle_adder
//   Adds or subtracts two WIDTH-bit operands SLICE bits per clock, using a
//   registered carry between slices. An operation takes N = WIDTH/SLICE
//   RUN cycles, followed by a single DONE cycle.
//
//   Ports
//     clk    rising-edge clock
//     rst    synchronous active-high reset
//     start  begin an operation (only sampled while ready=1)
//     sub    0 = add, 1 = subtract (captured with start)
//     a, b   operands (captured with start)
//     cin    carry-in for add, borrow-in for sub (captured with start)
//     ready  high only in IDLE
//     done   one-cycle pulse when the result is complete
//     sum    registered result
//     cout   raw carry out of the MSB (for sub, 1 = no borrow)
//     ovf    two's-complement signed overflow
module multicycle_adder #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [KW-1:0]    k;
    logic             carry;
    // Operands shift right by one slice per RUN cycle, so the slice being
    // processed is always in the low SLICE bits.
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    // Operand sign bits are kept aside because the shifting destroys them
    // before the overflow decision on the last slice.
    logic             a_msb;
    logic             b_msb;
    logic [SLICE:0]   slice_sum;
    logic             last;

    always_comb begin
        slice_sum = {1'b0, op_a[SLICE-1:0]} + {1'b0, op_b[SLICE-1:0]}
                  + {{SLICE{1'b0}}, carry};
        last      = (k == KW'(N - 1));
    end

    assign ready = (state == S_IDLE);
    assign done  = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            k     <= '0;
            carry <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + ~cin; inverting at capture
                        // turns RUN into a plain adder for both operations.
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? ~cin : cin;
                        a_msb <= a[WIDTH-1];
                        b_msb <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
                        k     <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    op_a  <= op_a >> SLICE;
                    op_b  <= op_b >> SLICE;
                    carry <= slice_sum[SLICE];
                    k     <= k + KW'(1);
                    for (int i = 0; i < N; i++) begin
                        if (k == KW'(i))
                            sum[i*SLICE +: SLICE] <= slice_sum[SLICE-1:0];
                    end
                    if (last) begin
                        cout  <= slice_sum[SLICE];
                        ovf   <= (a_msb == b_msb) && (slice_sum[SLICE-1] != a_msb);
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/multicycle_adder.md
MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand/result width in bits.
REQ-002 The block SHALL have parameter SLICE, default 4, meaning bits added per clock; WIDTH SHALL be an integer multiple of SLICE; N = WIDTH/SLICE.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset: port clk input 1 (rising-edge clock), then port rst input 1 (synchronous active-high reset).
REQ-004 The block SHALL have port start input 1: request to begin an operation; sampled only when ready=1.
REQ-005 The block SHALL have port sub input 1: 0 = add, 1 = subtract; captured with start.
REQ-006 The block SHALL have port a input WIDTH: operand A; captured with start.
REQ-007 The block SHALL have port b input WIDTH: operand B; captured with start.
REQ-008 The block SHALL have port cin input 1: carry-in (add) or borrow-in (sub); captured with start.
REQ-009 The block SHALL have port ready output 1: high only in IDLE.
REQ-010 The block SHALL have port done output 1: one-cycle pulse when the result is complete.
REQ-011 The block SHALL have port sum output WIDTH: registered result.
REQ-012 The block SHALL have port cout output 1: raw carry out of the MSB.
REQ-013 The block SHALL have port ovf output 1: two's-complement signed overflow.

Function
REQ-014 Arithmetic: add SHALL give {cout,sum} = a + b + cin; sub SHALL give {cout,sum} = a + ~b + ~cin, i.e. sum = a - b - cin mod 2^WIDTH, with cout=1 meaning no borrow.
REQ-015 ovf SHALL be 1 iff a[MSB] equals the effective B MSB (b[MSB] for add, ~b[MSB] for sub) and sum[MSB] differs from a[MSB].
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
REQ-017 IDLE -> RUN on a clock edge with start=1: a, b (inverted if sub), cin (inverted if sub) and sub captured; slice counter cleared to 0.
REQ-018 In RUN, each clock edge SHALL add slice k (bits k*SLICE+SLICE-1 .. k*SLICE) with the registered carry, write that slice of sum, store the slice carry-out as the next carry, and increment k.
REQ-019 RUN -> DONE on the edge processing slice N-1; cout and ovf SHALL be updated on that same edge.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-021 Latency: with start sampled at edge 0, done SHALL be high in the cycle after edge N, i.e. between edges N and N+1.
REQ-022 start while in RUN or DONE SHALL be ignored; input changes after capture SHALL not affect the operation in flight.
REQ-023 start is not accepted in the DONE cycle; back-to-back operations require start to be sampled in IDLE, giving a minimum issue interval of N+2 cycles.
REQ-024 sum, cout and ovf SHALL hold their last completed values in IDLE until the next operation overwrites them; mid-operation values of sum are undefined to the user.
REQ-025 SLICE = WIDTH (N=1) SHALL be legal and give done 2 cycles after start.

Reset
REQ-026 While rst=1 at a clock edge: state SHALL go to IDLE, slice counter and carry to 0, sum to 0, cout=0, ovf=0, done=0; in the following cycle ready=1.
REQ-027 rst SHALL take priority over start and SHALL abort an operation in RUN or DONE with no done pulse.

Verification (WIDTH=16, SLICE=4)
REQ-028 Add: a=0x1234, b=0x0FED, cin=1 -> done in the cycle after edge 4; sum=0x2222, cout=0, ovf=0.
REQ-029 Carry chain: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, ovf=0.
REQ-030 Signed overflow: a=0x7FFF, b=0x0001, cin=0 (add) -> sum=0x8000, ovf=1, cout=0; sub a=0x8000, b=0x0001, cin=0 -> sum=0x7FFF, ovf=1, cout=1.
REQ-031 Borrow: sub a=0x0003, b=0x0005, cin=1 -> sum=0xFFFD, cout=0, ovf=0.
REQ-032 start held high with a and b changed during RUN -> exactly one done pulse, result from the captured operands, ready low for 5 cycles.
REQ-033 rst asserted at edge 2 of RUN -> no done pulse; sum=0, cout=0, ovf=0; ready=1 in the next cycle; a new start then completes normally.
